dmem_hs: RTL and testbench
==========================

DMEM_HS -- requirements
Module: dmem_hs

Interface
REQ-001 SHALL have parameter LOG2_WORDS, default 8, meaning log2 of the number of 32-bit RAM words.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-003 SHALL have parameter N_MMIO, default 2, meaning the number of read-only 32-bit MMIO status words.
REQ-004 SHALL have parameter MMIO_BASE, default 32'hFFFF_FF00, meaning the byte address of MMIO word 0.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1 bit: request present.
REQ-008 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both high.
REQ-009 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-010 SHALL have port req_funct3, input, 3 bits: size/sign code; LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-011 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-012 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-013 SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata, output, 32 bits: load result, extended.
REQ-015 SHALL have port rsp_err, output, 1 bit: access fault, valid with rsp_valid.
REQ-016 SHALL have port mmio_in, input, N_MMIO*32 bits: status words; word k occupies bits [32k+31:32k].
REQ-017 SHALL have port busy, output, 1 bit: high while clearing.

Function
REQ-018 SHALL implement FSM states CLEAR and RUN; CLEAR→RUN after the clear counter writes word 2^LOG2_WORDS-1.
REQ-019 In CLEAR, SHALL write 0 to RAM word[cnt] each cycle, cnt counting 0..2^LOG2_WORDS-1, with req_ready=0 and busy=1.
REQ-020 In RUN, SHALL hold req_ready=1 and busy=0, accepting one request per cycle back-to-back.
REQ-021 SHALL assert rsp_valid exactly one cycle after each accepted request; latency is fixed at 1 with no response backpressure.
REQ-022 Store SHALL write at the accept edge, little-endian; SB writes lane addr[1:0], SH writes halfword addr[1], SW writes the whole word; other bytes are unchanged.
REQ-023 Store response SHALL carry rsp_rdata=0.
REQ-024 Load SHALL select the byte/halfword as in REQ-022; LB/LH sign-extend, LBU/LHU zero-extend, LW is unmodified.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-026 RAM region: word index = addr[LOG2_WORDS+1:2], valid only when addr < 4*2^LOG2_WORDS.
REQ-027 MMIO region: MMIO_BASE <= addr < MMIO_BASE+4*N_MMIO; loads SHALL return mmio_in word (addr-MMIO_BASE)>>2 as sampled at the accept edge, with the same size/extension rules.
REQ-028 SHALL flag rsp_err=1 with rsp_rdata=0 and no RAM change on any of:
- misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0;
- illegal funct3: load 011/110/111, or store other than 000/001/010;
- address in neither region;
- any store to MMIO.
REQ-029 Otherwise rsp_err SHALL be 0.

Reset
REQ-030 While rst=1, at each edge: state←CLEAR, cnt←0, rsp_valid←0, rsp_err←0, rsp_rdata←0; req_ready=0 and busy=1.
REQ-031 Clearing SHALL begin on the first edge with rst=0.
REQ-032 Reset in RUN SHALL discard any pending response, with no rsp_valid in the following cycle.
REQ-033 Reset in CLEAR SHALL restart the counter from 0.
REQ-034 RAM SHALL read all-zero once busy falls.

Verification
REQ-035 Release rst → busy=1 for exactly 256 cycles (LOG2_WORDS=8), then req_ready=1; LW 0x00 → rdata 0, err 0.
REQ-036 SW 0x10=0x8000_80F0, then LB 0x10 → 0xFFFF_FFF0, LBU 0x11 → 0x0000_0080, LH 0x12 → 0xFFFF_8000, LHU 0x12 → 0x0000_8000.
REQ-037 SB 0x21=0xAB over word 0x1122_3344, then LW 0x20 → 0x1122_AB44; back-to-back requests give rsp_valid on consecutive cycles.
REQ-038 Faults, each err=1 with memory unchanged:
- LW 0x02;
- SH 0x05;
- funct3=011 load;
- LW 0x400;
- SW to MMIO_BASE.
REQ-039 mmio_in word1=0xDEAD_BEEF: LW MMIO_BASE+4 → 0xDEAD_BEEF; LBU MMIO_BASE+7 → 0xDE.
REQ-040 rst pulsed the cycle after an accepted load → no rsp_valid, busy=1, clear restarts from word 0.

Source files
------------

// File: rtl/dmem_hs.sv
// Data memory with valid/ready request port, 1-cycle response,
// zero-fill after reset and a small read-only MMIO status window.
module dmem_hs #(
   parameter int                LOG2_WORDS = 8,
   parameter int                ADDR_W     = 32,
   parameter int                N_MMIO     = 2,
   parameter logic [ADDR_W-1:0] MMIO_BASE  = 32'hFFFF_FF00
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [31:0]         req_wdata,
   output logic                rsp_valid,
   output logic [31:0]         rsp_rdata,
   output logic                rsp_err,
   input  logic [N_MMIO*32-1:0] mmio_in,
   output logic                busy
);

   localparam int WORDS = 2 ** LOG2_WORDS;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state_q, state_d;
   logic [LOG2_WORDS-1:0] cnt_q, cnt_d;

   logic [31:0] mem [WORDS];

   logic                  accept;
   logic [LOG2_WORDS-1:0] widx;
   logic                  in_ram;
   logic                  in_mmio;
   logic [ADDR_W-2:0]     moff;
   logic [31:0]           mword;
   logic [31:0]           rword;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [31:0]           ldata;
   logic                  legal;
   logic                  misalign;
   logic                  fault;
   logic [3:0]            be;
   logic [31:0]           wlane;
   logic                  wr_en;
   logic                  rsp_q;

   // Next-state and handshake outputs; reset forces the not-ready view.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LOG2_WORDS'(WORDS - 1))
               state_d = RUN;
         end
         RUN: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
      endcase
      if (rst) begin
         req_ready = 1'b0;
         busy      = 1'b1;
      end
   end

   // State register and clear counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign accept = req_valid & req_ready;
   assign widx   = req_addr[LOG2_WORDS+1:2];
   assign in_ram = (req_addr[ADDR_W-1:LOG2_WORDS+2] == '0);

   // Word offset into the MMIO window; a negative offset wraps huge.
   assign moff    = {1'b0, req_addr[ADDR_W-1:2]}
                  - {1'b0, MMIO_BASE[ADDR_W-1:2]};
   assign in_mmio = !in_ram && (moff < (ADDR_W-1)'(N_MMIO));

   // Pick the addressed MMIO status word.
   always_comb begin
      mword = '0;
      for (int k = 0; k < N_MMIO; k++)
         if (moff == (ADDR_W-1)'(k))
            mword = mmio_in[k*32 +: 32];
   end

   // Access legality: size/sign code, alignment, region, MMIO stores.
   always_comb begin
      legal = 1'b0;
      unique case (req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !req_we;
         default:                legal = 1'b0;
      endcase
      misalign = (req_funct3[1:0] == 2'b01 && req_addr[0])
              || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      fault = !legal || misalign || !(in_ram || in_mmio)
           || (req_we && in_mmio);
   end

   // Load lane select and extension.
   always_comb begin
      rword  = in_ram ? mem[widx] : mword;
      byte_v = rword[{req_addr[1:0], 3'b000} +: 8];
      half_v = req_addr[1] ? rword[31:16] : rword[15:0];
      ldata  = rword;
      unique case (req_funct3[1:0])
         2'b00:   ldata = {{24{!req_funct3[2] & byte_v[7]}}, byte_v};
         2'b01:   ldata = {{16{!req_funct3[2] & half_v[15]}}, half_v};
         default: ldata = rword;
      endcase
   end

   // Store byte enables and replicated lane data.
   always_comb begin
      be    = 4'b1111;
      wlane = req_wdata;
      unique case (req_funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << req_addr[1:0];
            wlane = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be    = req_addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{req_wdata[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = req_wdata;
         end
      endcase
   end

   assign wr_en = accept && req_we && !fault;

   // RAM write port: zero-fill while clearing, byte-masked stores in run.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
         end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
               if (be[b])
                  mem[widx][b*8 +: 8] <= wlane[b*8 +: 8];
         end
      end
   end

   // Response register, one cycle behind acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_q     <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_q     <= accept;
         rsp_err   <= accept && fault;
         rsp_rdata <= (accept && !fault && !req_we) ? ldata : '0;
      end
   end

   assign rsp_valid = rsp_q && !rst;

endmodule

// File: tb/tb_dmem_hs.sv
// Scoreboard bench for dmem_hs: directed requests push expected
// responses; a monitor pops and compares on every rsp_valid.
module tb_dmem_hs;

   localparam logic [31:0] MB = 32'hFFFF_FF00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b010;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [63:0] mmio_in = {32'hDEAD_BEEF, 32'h0123_4567};
   logic        busy;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   dmem_hs dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mmio_in(mmio_in), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare each response against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rsp_valid === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp cyc=%0d rdata=%h err=%b",
                     cyc, rsp_rdata, rsp_err);
         end else begin
            e = q.pop_front();
            if (cyc != e.cyc || rsp_rdata !== e.rdata
                || rsp_err !== e.err) begin
               errors++;
               $display("FAIL rsp cyc=%0d rdata=%h err=%b want cyc=%0d rdata=%h err=%b",
                        cyc, rsp_rdata, rsp_err, e.cyc, e.rdata, e.err);
            end
         end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
         checks++;
         errors++;
         e = q.pop_front();
         $display("FAIL missing_rsp cyc=%0d want rdata=%h at cyc=%0d",
                  cyc, e.rdata, e.cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, req);
      end
   endtask

   // Present one request at a negedge; expected response is queued.
   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
      exp_t e;
      check("req_ready", {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc + 1;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   // Release reset at a negedge and measure how long busy stays high.
   task automatic wait_clear(input string name);
      int n;
      n = 0;
      rst = 1'b0;
      #1;
      while (busy === 1'b1 && n < 2000) begin
         n++;
         @(negedge clk);
         #1;
      end
      check(name, n, 32'd256);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", {31'b0, busy}, 32'd1);
      check("rst_ready", {31'b0, req_ready}, 32'd0);
      check("rst_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", {31'b0, rsp_err}, 32'd0);
      @(negedge clk);

      // Reset in the middle of clearing restarts the counter.
      rst = 1'b0;
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      wait_clear("clear_len");
      check("run_ready", {31'b0, req_ready}, 32'd1);

      issue(0, 3'b010, 32'h00, 0, 32'h0, 0);

      issue(1, 3'b010, 32'h10, 32'h8000_80F0, 32'h0, 0);
      issue(0, 3'b000, 32'h10, 0, 32'hFFFF_FFF0, 0);
      issue(0, 3'b100, 32'h11, 0, 32'h0000_0080, 0);
      issue(0, 3'b001, 32'h12, 0, 32'hFFFF_8000, 0);
      issue(0, 3'b101, 32'h12, 0, 32'h0000_8000, 0);

      issue(1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 0);
      issue(1, 3'b000, 32'h21, 32'hFFFF_FFAB, 32'h0, 0);
      issue(0, 3'b010, 32'h20, 0, 32'h1122_AB44, 0);
      issue(1, 3'b001, 32'h22, 32'hFFFF_7788, 32'h0, 0);
      issue(0, 3'b010, 32'h20, 0, 32'h7788_AB44, 0);
      idle();

      issue(0, 3'b010, 32'h02, 0, 32'h0, 1);
      issue(1, 3'b001, 32'h05, 32'hFFFF, 32'h0, 1);
      issue(0, 3'b010, 32'h04, 0, 32'h0, 0);
      issue(0, 3'b011, 32'h10, 0, 32'h0, 1);
      issue(1, 3'b100, 32'h10, 32'h0, 32'h0, 1);
      issue(0, 3'b010, 32'h10, 0, 32'h8000_80F0, 0);
      issue(0, 3'b010, 32'h400, 0, 32'h0, 1);
      issue(0, 3'b010, 32'h3FC, 0, 32'h0, 0);
      issue(1, 3'b010, MB, 32'h1234_5678, 32'h0, 1);
      issue(0, 3'b010, MB, 0, 32'h0123_4567, 0);

      issue(0, 3'b010, MB + 4, 0, 32'hDEAD_BEEF, 0);
      issue(0, 3'b100, MB + 7, 0, 32'h0000_00DE, 0);
      issue(0, 3'b000, MB + 4, 0, 32'hFFFF_FFEF, 0);
      issue(0, 3'b001, MB + 2, 0, 32'h0000_0123, 0);
      issue(0, 3'b010, MB + 8, 0, 32'h0, 1);
      issue(0, 3'b010, MB - 4, 0, 32'h0, 1);

      issue(1, 3'b010, 32'h000, 32'hCAFE_F00D, 32'h0, 0);
      issue(1, 3'b010, 32'h3FC, 32'h5555_AAAA, 32'h0, 0);
      issue(0, 3'b010, 32'h3FC, 0, 32'h5555_AAAA, 0);
      idle();

      // Load accepted, then reset next cycle: response is dropped.
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h000;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("drop_valid", {31'b0, rsp_valid}, 32'd0);
      check("drop_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      #1;
      check("drop_valid2", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      wait_clear("reclear_len");

      issue(0, 3'b010, 32'h000, 0, 32'h0, 0);
      issue(0, 3'b010, 32'h3FC, 0, 32'h0, 0);
      issue(0, 3'b010, 32'h020, 0, 32'h0, 0);
      idle();
      idle();
      idle();

      check("queue_empty", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout cyc=%0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $fatal(1, "timeout");
   end

endmodule
